alu16_seq: RTL and testbench

ALU16_SEQ -- requirements
Module: alu16_seq

---
 rtl/alu16_seq.sv | 150 +++++++++++++++
 tb/tb_alu16_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu16_seq.sv
// alu16_seq: performs a 16-bit add as two passes through an external 8-bit ALU.
// The low bytes go through first with ALU_ADD_OP, then the high bytes with
// ALU_ADC_OP, using the low-pass carry as carry-in.
//   mode 0 : ADD HL,rr  (Z kept from flags_in, H/C from the high pass)
//   mode 1 : ADD SP,e8  (op_b[7:0] sign-extended, Z=0, H/C from the low pass)
// Optional feature macro: ALU16_SEQ_SPADD_EN. When it is undefined, mode is
// ignored and every operation runs as mode 0.
// Ports:
//   clk, rst (async, active-high)
//   start, mode, op_a[15:0], op_b[15:0], flags_in[7:0]  - request
//   alu_a[7:0], alu_b[7:0], alu_opcode[3:0], alu_carry_in - to 8-bit ALU
//   alu_res[7:0], alu_flags[7:0]                          - from 8-bit ALU
//   busy, done, result[15:0], flags_out[7:0]              - status/result
// Flag layout: Z=bit7, N=bit6, H=bit5, C=bit4, bits[3:0]=0.
module alu16_seq #(
  parameter logic [3:0] ALU_ADD_OP = 4'b0000,
  parameter logic [3:0] ALU_ADC_OP = 4'b0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [7:0]  flags_in,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_opcode,
  output logic        alu_carry_in,
  input  logic [7:0]  alu_res,
  input  logic [7:0]  alu_flags,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  flags_out
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        z_q;
  logic [7:0]  lo_byte_q;
  logic        lo_h_q;
  logic        lo_c_q;
  logic [15:0] b_eff;
  logic [7:0]  flags_new;

  // Only Z of flags_in and H/C of alu_flags are consumed.
  logic [12:0] unused_bits;
  assign unused_bits = {flags_in[6:0], alu_flags[7:6], alu_flags[3:0]};

`ifdef ALU16_SEQ_SPADD_EN
  logic               mode_q;
  logic signed [7:0]  e8;
  logic signed [15:0] e8_ext;

  assign e8     = op_b[7:0];
  assign e8_ext = e8;  // signed-to-signed assignment sign-extends
  assign b_eff  = mode ? e8_ext : op_b;

  // SP+e8 reports the low-pass (byte) carries and always clears Z.
  assign flags_new = mode_q ? {2'b00, lo_h_q, lo_c_q, 4'b0000}
                            : {z_q, 1'b0, alu_flags[5], alu_flags[4], 4'b0000};
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign b_eff       = op_b;
  assign flags_new   = {z_q, 1'b0, alu_flags[5], alu_flags[4], 4'b0000};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_opcode   = ALU_ADD_OP;
    alu_carry_in = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LO;
      LO: begin
        alu_a     = a_q[7:0];
        alu_b     = b_q[7:0];
        busy      = 1'b1;
        state_nxt = HI;
      end
      HI: begin
        alu_a        = a_q[15:8];
        alu_b        = b_q[15:8];
        alu_opcode   = ALU_ADC_OP;
        alu_carry_in = lo_c_q;
        busy         = 1'b1;
        state_nxt    = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      z_q       <= 1'b0;
      lo_byte_q <= 8'h00;
      lo_h_q    <= 1'b0;
      lo_c_q    <= 1'b0;
      result    <= 16'h0000;
      flags_out <= 8'h00;
`ifdef ALU16_SEQ_SPADD_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      case (state)
        // accept: capture operands
        IDLE: if (start) begin
          a_q <= op_a;
          b_q <= b_eff;
          z_q <= flags_in[7];
`ifdef ALU16_SEQ_SPADD_EN
          mode_q <= mode;
`endif
        end
        // low pass -> high pass
        LO: begin
          lo_byte_q <= alu_res;
          lo_h_q    <= alu_flags[5];
          lo_c_q    <= alu_flags[4];
        end
        // high pass -> result
        HI: begin
          result    <= {alu_res, lo_byte_q};
          flags_out <= flags_new;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_seq.sv
module tb_alu16_seq;

  localparam logic [3:0] ADD_OP = 4'b0000;
  localparam logic [3:0] ADC_OP = 4'b0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [7:0]  flags_in;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic        alu_carry_in;
  logic [7:0]  alu_res, alu_flags;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  flags_out;

  int n_tests = 0;
  int n_fail  = 0;

  alu16_seq #(.ALU_ADD_OP(ADD_OP), .ALU_ADC_OP(ADC_OP)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .op_a(op_a), .op_b(op_b),
    .flags_in(flags_in), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_carry_in(alu_carry_in), .alu_res(alu_res), .alu_flags(alu_flags),
    .busy(busy), .done(done), .result(result), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  // Reference 8-bit ALU: ADD ignores carry-in, ADC uses it, other opcodes give 0.
  always_comb begin
    logic [8:0] s;
    logic [4:0] hn;
    logic       ci;
    ci        = (alu_opcode == ADC_OP) ? alu_carry_in : 1'b0;
    s         = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, ci};
    hn        = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, ci};
    alu_res   = 8'h00;
    alu_flags = 8'h00;
    if (alu_opcode == ADD_OP || alu_opcode == ADC_OP) begin
      alu_res   = s[7:0];
      alu_flags = {(s[7:0] == 8'h00), 1'b0, hn[4], s[8], 4'h0};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  fin;
    logic [15:0] exp_res;
    logic [7:0]  exp_flags;
    logic        exp_hi_cin;
  } vec_t;

  // Full transaction with cycle-by-cycle checks; start sampled at edge 0.
  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clk); #1;
    start = 1'b1; mode = v.mode; op_a = v.a; op_b = v.b; flags_in = v.fin;
    @(posedge clk); #1;                       // edge 0 -> LO
    start = 1'b0; op_a = 16'h0; op_b = 16'h0; flags_in = 8'h0; mode = 1'b0;
    chk({tag, " busy_lo"}, busy, 1);
    chk({tag, " done_lo"}, done, 0);
    @(posedge clk); #1;                       // edge 1 -> HI
    chk({tag, " busy_hi"}, busy, 1);
    chk({tag, " cin_hi"}, alu_carry_in, v.exp_hi_cin);
    @(posedge clk); #1;                       // edge 2 -> DONE
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_done"}, busy, 0);
    chk({tag, " result"}, result, v.exp_res);
    chk({tag, " flags"}, flags_out, v.exp_flags);
    @(posedge clk); #1;                       // edge 3 -> IDLE
    chk({tag, " done_off"}, done, 0);
    chk({tag, " result_hold"}, result, v.exp_res);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b0, 16'h0FFF, 16'h0001, 8'h80, 16'h1000, 8'hA0, 1'b1});
    vecs.push_back('{1'b0, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h30, 1'b1});
    vecs.push_back('{1'b0, 16'h1234, 16'h1111, 8'hFF, 16'h2345, 8'h80, 1'b0});
    vecs.push_back('{1'b0, 16'h8000, 16'h8000, 8'h00, 16'h0000, 8'h10, 1'b0});
    vecs.push_back('{1'b0, 16'h0F00, 16'h0100, 8'h7F, 16'h1000, 8'h20, 1'b0});
    vecs.push_back('{1'b0, 16'h00FF, 16'h00FF, 8'h00, 16'h01FE, 8'h00, 1'b1});
`ifdef ALU16_SEQ_SPADD_EN
    vecs.push_back('{1'b1, 16'hFFF8, 16'hAB08, 8'h00, 16'h0000, 8'h30, 1'b1});
    vecs.push_back('{1'b1, 16'h0000, 16'h00FF, 8'h80, 16'hFFFF, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 16'h00FF, 16'h5501, 8'h80, 16'h0100, 8'h30, 1'b1});
`else
    // mode is ignored: plain 16-bit add with Z from flags_in
    vecs.push_back('{1'b1, 16'hFFF8, 16'hAB08, 8'h00, 16'hAB00, 8'h30, 1'b1});
    vecs.push_back('{1'b1, 16'h0000, 16'h00FF, 8'h80, 16'h00FF, 8'h80, 1'b0});
`endif

    rst = 1'b1; start = 1'b0; mode = 1'b0; op_a = 16'h0; op_b = 16'h0; flags_in = 8'h0;
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst flags", flags_out, 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);
    chk("rst opcode", alu_opcode, ADD_OP);
    chk("rst cin", alu_carry_in, 0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start while in LO must be ignored.
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; op_a = 16'h0001; op_b = 16'h0002; flags_in = 8'h00;
    @(posedge clk); #1;                       // edge 0 -> LO
    op_a = 16'h1234; op_b = 16'h1234; flags_in = 8'h80;   // start still high
    @(posedge clk); #1;                       // edge 1 -> HI
    start = 1'b0;
    @(posedge clk); #1;                       // edge 2 -> DONE
    chk("ign result", result, 16'h0003);
    chk("ign flags", flags_out, 8'h00);
    chk("ign done", done, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ign idle busy", busy, 0);
    chk("ign idle done", done, 0);

    // Async reset in the middle of HI.
    @(posedge clk); #1;
    start = 1'b1; op_a = 16'hFFFF; op_b = 16'h0001; flags_in = 8'h80;
    @(posedge clk); #1; start = 1'b0;         // LO
    @(posedge clk); #2;                       // HI
    chk("mid busy_pre", busy, 1);
    rst = 1'b1; #1;
    chk("mid busy", busy, 0);
    chk("mid done", done, 0);
    chk("mid result", result, 0);
    chk("mid flags", flags_out, 0);
    chk("mid cin", alu_carry_in, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post rst done", done, 0);
    chk("post rst result", result, 0);
    run_vec(vecs[0], "fresh");

    // Back-to-back: next start accepted the edge after the DONE->IDLE edge.
    run_vec(vecs[2], "b2b_a");
    start = 1'b1; op_a = 16'h0F00; op_b = 16'h0100; flags_in = 8'h7F;
    @(posedge clk); #1; start = 1'b0;
    chk("b2b busy", busy, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b result", result, 16'h1000);
    chk("b2b flags", flags_out, 8'h20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
